// File: rtl/arb_mux_pkg.sv
// rtl/arb_mux_pkg.sv - shared defaults, lock state encoding and round-robin search helper for arb_mux
package arb_mux_pkg;

    localparam int ARB_MUX_BUS_WIDTH_DEF = 32;
    localparam int ARB_MUX_NUM_CH_DEF    = 4;

    typedef enum logic {
        LK_UNLOCKED = 1'b0,
        LK_LOCKED   = 1'b1
    } lock_state_t;

    // First set bit of req at or after ptr, wrapping; req bits beyond the channel count must be zero.
    function automatic logic [3:0] rr_next(input logic [3:0] ptr, input logic [15:0] req);
        logic [3:0] idx;
        logic       found;
        rr_next = ptr;
        found   = 1'b0;
        for (int i = 0; i < 16; i++) begin
            idx = ptr + 4'(i);
            if (!found && req[idx]) begin
                rr_next = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/arb_mux_rr_arbiter.sv
// rtl/arb_mux_rr_arbiter.sv - round-robin grant with rotating pointer and optional grant-hold lock (ARB_MUX_LOCK_EN)
module rr_arbiter
    import arb_mux_pkg::*;
#(
    parameter  int NUM_CH    = ARB_MUX_NUM_CH_DEF,
    localparam int SEL_WIDTH = $clog2(NUM_CH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_CH-1:0]    req,
    input  logic                 advance,
    input  logic [NUM_CH-1:0]    hold,
    output logic [NUM_CH-1:0]    gnt,
    output logic [SEL_WIDTH-1:0] gnt_idx
);

    logic [SEL_WIDTH-1:0] ptr;
    logic [SEL_WIDTH-1:0] ptr_nxt;
    logic [SEL_WIDTH-1:0] rr_idx;
    logic [SEL_WIDTH-1:0] win_idx;
    logic                 win_vld;
    logic                 xfer;

    function automatic logic [SEL_WIDTH-1:0] ptr_step(input logic [SEL_WIDTH-1:0] g);
        return (g == SEL_WIDTH'(NUM_CH - 1)) ? '0 : g + 1'b1;
    endfunction

    assign rr_idx  = SEL_WIDTH'(rr_next(4'(ptr), 16'(req)));
    assign xfer    = advance && win_vld;
    assign gnt_idx = win_idx;

    always_comb begin
        gnt = '0;
        if (win_vld) begin
            gnt[win_idx] = 1'b1;
        end
    end

`ifdef ARB_MUX_LOCK_EN
    lock_state_t          state;
    lock_state_t          state_nxt;
    logic [SEL_WIDTH-1:0] lock_ch;
    logic [SEL_WIDTH-1:0] lock_ch_nxt;

    // A locked owner keeps the grant even while idle; everyone else waits.
    always_comb begin
        win_idx = rr_idx;
        win_vld = |req;
        if (state == LK_LOCKED) begin
            win_idx = lock_ch;
            win_vld = req[lock_ch];
        end
    end

    always_comb begin
        state_nxt   = state;
        lock_ch_nxt = lock_ch;
        ptr_nxt     = ptr;
        if (xfer) begin
            unique case (state)
                LK_UNLOCKED: begin
                    ptr_nxt = ptr_step(win_idx);
                    if (hold[win_idx]) begin
                        state_nxt   = LK_LOCKED;
                        lock_ch_nxt = win_idx;
                    end
                end
                LK_LOCKED: begin
                    if (!hold[win_idx]) begin
                        state_nxt = LK_UNLOCKED;
                        ptr_nxt   = ptr_step(win_idx);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= LK_UNLOCKED;
            lock_ch <= '0;
            ptr     <= '0;
        end else begin
            state   <= state_nxt;
            lock_ch <= lock_ch_nxt;
            ptr     <= ptr_nxt;
        end
    end
`else
    logic unused_hold;

    assign unused_hold = ^hold;
    assign win_idx     = rr_idx;
    assign win_vld     = |req;
    assign ptr_nxt     = xfer ? ptr_step(win_idx) : ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_nxt;
        end
    end
`endif

endmodule

// File: rtl/arb_mux.sv
// rtl/arb_mux.sv - N-channel round-robin arbitrated mux with registered output slot; ARB_MUX_LOCK_EN adds lock_in grant hold
module arb_mux
    import arb_mux_pkg::*;
#(
    parameter  int BUS_WIDTH = ARB_MUX_BUS_WIDTH_DEF,
    parameter  int NUM_CH    = ARB_MUX_NUM_CH_DEF,
    localparam int SEL_WIDTH = $clog2(NUM_CH)
) (
    input  logic                        clk_in,
    input  logic                        rst_n_in,
    input  logic [NUM_CH-1:0]           valid_in,
    input  logic [NUM_CH*BUS_WIDTH-1:0] data_in,
    output logic [NUM_CH-1:0]           ready_out,
`ifdef ARB_MUX_LOCK_EN
    input  logic [NUM_CH-1:0]           lock_in,
`endif
    output logic                        valid_out,
    output logic [BUS_WIDTH-1:0]        data_out,
    output logic [SEL_WIDTH-1:0]        sel_out,
    input  logic                        ready_in
);

    logic                 load;
    logic                 xfer;
    logic [NUM_CH-1:0]    gnt;
    logic [NUM_CH-1:0]    hold;
    logic [SEL_WIDTH-1:0] gnt_idx;
    logic [BUS_WIDTH-1:0] load_data;

`ifdef ARB_MUX_LOCK_EN
    assign hold = lock_in;
`else
    assign hold = '0;
`endif

    // The slot may refill in the same cycle it drains, so a held ready_in gives full throughput.
    assign load      = !valid_out || ready_in;
    assign xfer      = load && (|gnt);
    assign ready_out = load ? gnt : '0;

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .clk     (clk_in),
        .rst_n   (rst_n_in),
        .req     (valid_in),
        .advance (load),
        .hold    (hold),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        load_data = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (gnt[k]) begin
                load_data = data_in[k*BUS_WIDTH +: BUS_WIDTH];
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            valid_out <= 1'b0;
            data_out  <= '0;
            sel_out   <= '0;
        end else if (xfer) begin
            valid_out <= 1'b1;
            data_out  <= load_data;
            sel_out   <= gnt_idx;
        end else if (ready_in) begin
            valid_out <= 1'b0;
        end
    end

    // Producers must hold a request and its payload until it is accepted.
    for (genvar k = 0; k < NUM_CH; k++) begin : g_src_chk
        a_src_stable: assert property (@(posedge clk_in) disable iff (!rst_n_in)
            (valid_in[k] && !ready_out[k]) |=>
            (valid_in[k] && $stable(data_in[k*BUS_WIDTH +: BUS_WIDTH])));
    end

endmodule

// File: tb/tb_arb_mux.sv
// tb/tb_arb_mux.sv - scoreboard bench for arb_mux with a queue-based round-robin reference model
module tb_arb_mux;

    localparam int BW = 32;
    localparam int N  = 4;
    localparam int SW = 2;

    logic            clk_in   = 1'b0;
    logic            rst_n_in = 1'b0;
    logic [N-1:0]    valid_in;
    logic [N*BW-1:0] data_in;
    logic [N-1:0]    ready_out;
    logic [N-1:0]    lock_in;
    logic            valid_out;
    logic [BW-1:0]   data_out;
    logic [SW-1:0]   sel_out;
    logic            ready_in;

    always #5 clk_in = ~clk_in;

    arb_mux #(.BUS_WIDTH(BW), .NUM_CH(N)) dut (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .ready_out (ready_out),
`ifdef ARB_MUX_LOCK_EN
        .lock_in   (lock_in),
`endif
        .valid_out (valid_out),
        .data_out  (data_out),
        .sel_out   (sel_out),
        .ready_in  (ready_in)
    );

    int checks = 0;
    int errors = 0;
    int reset_count = 0;

    bit          pend[N];
    logic [31:0] pdata[N];
    bit          lk[N];

    int m_ptr = 0;
    bit m_valid = 0;
    bit m_locked = 0;
    int m_lock_ch = 0;

    logic [31:0] exp_data[$];
    int          exp_sel[$];
    int          obs_sel[$];

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic apply();
        for (int k = 0; k < N; k++) begin
            valid_in[k]          = pend[k];
            data_in[k*BW +: BW]  = pdata[k];
            lock_in[k]           = lk[k];
        end
    endtask

    task automatic offer(input int k, input logic [31:0] d);
        if (!pend[k]) begin
            pend[k]  = 1'b1;
            pdata[k] = d;
        end
    endtask

    function automatic int model_winner();
        if (m_locked) return pend[m_lock_ch] ? m_lock_ch : -1;
        for (int i = 0; i < N; i++) begin
            if (pend[(m_ptr + i) % N]) return (m_ptr + i) % N;
        end
        return -1;
    endfunction

    // One clock: predict and check at the falling edge, advance the model after the rising edge.
    task automatic cycle();
        int           g;
        logic [N-1:0] exp_rdy;
        @(negedge clk_in);
        g = (!m_valid || ready_in) ? model_winner() : -1;
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk(ready_out == exp_rdy, "ready_out", ready_out, exp_rdy);
        chk(valid_out == m_valid, "valid_out", valid_out, m_valid);
        if (g >= 0) begin
            exp_data.push_back(pdata[g]);
            exp_sel.push_back(g);
        end
        @(posedge clk_in);
        #1;
        if (g >= 0) begin
            if (!m_locked) begin
                m_ptr = (g + 1) % N;
                if (lk[g]) begin
                    m_locked  = 1'b1;
                    m_lock_ch = g;
                end
            end else if (!lk[g]) begin
                m_locked = 1'b0;
                m_ptr    = (g + 1) % N;
            end
            m_valid = 1'b1;
            pend[g] = 1'b0;
        end else if (m_valid && ready_in) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic do_reset(input bit clear);
        #1 rst_n_in = 1'b0;
        #1;
        chk(valid_out == 1'b0, "rst_valid_out", valid_out, 0);
        chk(data_out == '0, "rst_data_out", data_out, 0);
        chk(sel_out == '0, "rst_sel_out", sel_out, 0);
        reset_count++;
        m_valid  = 1'b0;
        m_ptr    = 0;
        m_locked = 1'b0;
        exp_data.delete();
        exp_sel.delete();
        obs_sel.delete();
        if (clear) begin
            for (int k = 0; k < N; k++) begin
                pend[k] = 1'b0;
                lk[k]   = 1'b0;
            end
            apply();
        end
        @(posedge clk_in);
        #1 rst_n_in = 1'b1;
    endtask

    // Monitor: pops the scoreboard on every output transfer and checks stall stability.
    initial begin : monitor
        bit          st_have = 1'b0;
        int          st_rc = 0;
        logic [31:0] st_d = '0;
        logic [SW-1:0] st_s = '0;
        logic [31:0] ed;
        int          es;
        forever begin
            @(negedge clk_in);
            if (rst_n_in) begin
                if (st_have && st_rc == reset_count) begin
                    chk(data_out == st_d, "stall_data", data_out, st_d);
                    chk(sel_out == st_s, "stall_sel", sel_out, st_s);
                end
                st_have = 1'b0;
                if (valid_out && ready_in) begin
                    if (exp_sel.size() == 0) begin
                        chk(1'b0, "unexpected_beat", sel_out, 0);
                    end else begin
                        ed = exp_data.pop_front();
                        es = exp_sel.pop_front();
                        chk(data_out == ed, "beat_data", data_out, ed);
                        chk(int'(sel_out) == es, "beat_sel", sel_out, es);
                        obs_sel.push_back(int'(sel_out));
                    end
                end else if (valid_out) begin
                    st_have = 1'b1;
                    st_d    = data_out;
                    st_s    = sel_out;
                    st_rc   = reset_count;
                end
            end
        end
    end

    initial begin : stimulus
        for (int k = 0; k < N; k++) begin
            pend[k]  = 1'b0;
            pdata[k] = '0;
            lk[k]    = 1'b0;
        end
        ready_in = 1'b0;
        apply();
        repeat (2) @(posedge clk_in);
        #1;
        chk(valid_out == 1'b0, "init_valid_out", valid_out, 0);
        chk(data_out == '0, "init_data_out", data_out, 0);
        chk(sel_out == '0, "init_sel_out", sel_out, 0);
        chk(ready_out == '0, "init_ready_out", ready_out, 0);
        rst_n_in = 1'b1;

        // Single request on channel 2, then the pointer must favour channel 3 over 0.
        ready_in = 1'b1;
        offer(2, 32'hA5A5_0002);
        apply();
        cycle();
        chk(valid_out == 1'b1, "t1_valid", valid_out, 1);
        chk(data_out == 32'hA5A5_0002, "t1_data", data_out, 32'hA5A5_0002);
        chk(sel_out == 2'd2, "t1_sel", sel_out, 2);
        offer(0, $urandom);
        offer(3, $urandom);
        apply();
        cycle();
        chk(sel_out == 2'd3, "t1_ptr_next", sel_out, 3);

        // Fairness with every channel requesting.
        do_reset(1'b1);
        for (int c = 0; c < 9; c++) begin
            for (int k = 0; k < N; k++) offer(k, $urandom);
            apply();
            cycle();
        end
        chk(obs_sel.size() >= 8, "t2_beats", obs_sel.size(), 8);
        for (int i = 0; i < 8 && i < obs_sel.size(); i++) begin
            chk(obs_sel[i] == i % N, "t2_rr_order", obs_sel[i], i % N);
        end

        // Backpressure with a full slot, then drain and load together.
        ready_in = 1'b0;
        apply();
        for (int c = 0; c < 3; c++) begin
            #1 chk(ready_out == '0, "t3_bp_ready", ready_out, 0);
            cycle();
        end
        ready_in = 1'b1;
        apply();
        cycle();
        chk(valid_out == 1'b1, "t3_drain_load", valid_out, 1);

        // Asynchronous reset with a beat in the slot.
        chk(valid_out == 1'b1, "t4_pre_valid", valid_out, 1);
        do_reset(1'b0);
        for (int c = 0; c < 3; c++) begin
            for (int k = 0; k < N; k++) offer(k, $urandom);
            apply();
            cycle();
        end
        if (obs_sel.size() == 0) chk(1'b0, "t4_first_grant", 0, 0);
        else chk(obs_sel[0] == 0, "t4_first_grant", obs_sel[0], 0);

`ifdef ARB_MUX_LOCK_EN
        // Channel 1 locks for three beats while channel 3 waits.
        do_reset(1'b1);
        offer(3, $urandom);
        for (int b = 0; b < 3; b++) begin
            offer(1, $urandom);
            lk[1] = (b < 2);
            apply();
            cycle();
        end
        lk[1] = 1'b0;
        apply();
        cycle();
        cycle();
        begin
            int exp5[4] = '{1, 1, 1, 3};
            chk(obs_sel.size() >= 4, "t5_beats", obs_sel.size(), 4);
            for (int i = 0; i < 4 && i < obs_sel.size(); i++) begin
                chk(obs_sel[i] == exp5[i], "t5_lock_order", obs_sel[i], exp5[i]);
            end
        end

        // Locked owner idle: channel 0 must not be granted.
        do_reset(1'b1);
        offer(1, $urandom);
        lk[1] = 1'b1;
        apply();
        cycle();
        lk[1] = 1'b0;
        offer(0, $urandom);
        apply();
        for (int c = 0; c < 2; c++) begin
            #1 chk(ready_out == '0, "t6_locked_idle", ready_out, 0);
            cycle();
        end
        offer(1, $urandom);
        apply();
        cycle();
        cycle();
        cycle();
        begin
            int exp6[3] = '{1, 1, 0};
            chk(obs_sel.size() >= 3, "t6_beats", obs_sel.size(), 3);
            for (int i = 0; i < 3 && i < obs_sel.size(); i++) begin
                chk(obs_sel[i] == exp6[i], "t6_lock_order", obs_sel[i], exp6[i]);
            end
        end
`endif

        // Randomised traffic with random backpressure.
        for (int c = 0; c < 400; c++) begin
            ready_in = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 1) == 1) offer(k, $urandom);
`ifdef ARB_MUX_LOCK_EN
                lk[k] = ($urandom_range(0, 4) == 0);
`endif
            end
            apply();
            cycle();
        end

        // Drain everything, releasing any lock.
        ready_in = 1'b1;
        for (int k = 0; k < N; k++) lk[k] = 1'b0;
        begin
            int  budget = 60;
            bit  busy = 1'b1;
            while (busy && budget > 0) begin
                if (m_locked && !pend[m_lock_ch]) offer(m_lock_ch, $urandom);
                apply();
                cycle();
                budget--;
                busy = m_valid;
                for (int k = 0; k < N; k++) busy |= pend[k];
            end
            chk(!busy, "drain_budget", busy, 0);
        end
        chk(exp_sel.size() == 0, "sb_empty", exp_sel.size(), 0);
        chk(valid_out == 1'b0, "final_valid", valid_out, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
